// File: rtl/bram_pkg.sv
// Shared types and helpers for the dual-port byte-enable block RAM.
package bram_pkg;

  typedef enum logic [1:0] {
    WM_READ_FIRST,
    WM_WRITE_FIRST,
    WM_NO_CHANGE
  } wr_mode_e;

  // Bits needed to represent value; never less than 1.
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int num_bytes(input int width);
    return width / 8;
  endfunction

  // Even parity: stored bit makes the byte plus parity bit carry an even count of ones.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/bram_out_pipe.sv
// Per-port read output stage: 1 or 2 register stages carrying data, valid, parity error and
// collision tag. Data holds while no valid access is in flight.
module bram_out_pipe #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vld_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             perr_in,
  input  logic             coll_in,
  output logic [WIDTH-1:0] data_out,
  output logic             vld_out,
  output logic             perr_out,
  output logic             coll_out
);

  logic [WIDTH-1:0] s1_data_q, s1_data_d;
  logic             s1_vld_q, s1_vld_d;
  logic             s1_perr_q, s1_perr_d;
  logic             s1_coll_q, s1_coll_d;

  always_comb begin
    s1_data_d = vld_in ? data_in : s1_data_q;
    s1_vld_d  = vld_in;
    s1_perr_d = vld_in & perr_in;
    s1_coll_d = coll_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data_q <= '0;
      s1_vld_q  <= 1'b0;
      s1_perr_q <= 1'b0;
      s1_coll_q <= 1'b0;
    end else begin
      s1_data_q <= s1_data_d;
      s1_vld_q  <= s1_vld_d;
      s1_perr_q <= s1_perr_d;
      s1_coll_q <= s1_coll_d;
    end
  end

  if (LATENCY == 2) begin : g_lat2
    logic [WIDTH-1:0] s2_data_q, s2_data_d;
    logic             s2_vld_q, s2_vld_d;
    logic             s2_perr_q, s2_perr_d;
    logic             s2_coll_q, s2_coll_d;

    always_comb begin
      s2_data_d = s1_vld_q ? s1_data_q : s2_data_q;
      s2_vld_d  = s1_vld_q;
      s2_perr_d = s1_vld_q & s1_perr_q;
      s2_coll_d = s1_coll_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_data_q <= '0;
        s2_vld_q  <= 1'b0;
        s2_perr_q <= 1'b0;
        s2_coll_q <= 1'b0;
      end else begin
        s2_data_q <= s2_data_d;
        s2_vld_q  <= s2_vld_d;
        s2_perr_q <= s2_perr_d;
        s2_coll_q <= s2_coll_d;
      end
    end

    assign data_out = s2_data_q;
    assign vld_out  = s2_vld_q;
    assign perr_out = s2_perr_q;
    assign coll_out = s2_coll_q;
  end else begin : g_lat1
    assign data_out = s1_data_q;
    assign vld_out  = s1_vld_q;
    assign perr_out = s1_perr_q;
    assign coll_out = s1_coll_q;
  end

endmodule

// File: rtl/bram_dual_be.sv
// True dual-port block RAM with byte write enables, selectable write mode and collision flag.
// Optional per-byte even parity storage when BRAM_DUAL_PARITY_EN is defined.
module bram_dual_be
  import bram_pkg::*;
#(
  parameter int    RAM_WIDTH    = 32,
  parameter int    RAM_DEPTH    = 512,
  parameter int    READ_LATENCY = 1,
  parameter string WRITE_MODE   = "READ_FIRST",
  parameter string INIT_FILE    = "",
  localparam int   NB           = num_bytes(RAM_WIDTH),
  localparam int   AW           = clogb2(RAM_DEPTH - 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 enb,
  input  logic [NB-1:0]        wea,
  input  logic [NB-1:0]        web,
  input  logic [AW-1:0]        addra,
  input  logic [AW-1:0]        addrb,
  input  logic [RAM_WIDTH-1:0] dina,
  input  logic [RAM_WIDTH-1:0] dinb,
  output logic [RAM_WIDTH-1:0] douta,
  output logic [RAM_WIDTH-1:0] doutb,
  output logic                 dvalida,
  output logic                 dvalidb,
  output logic                 coll,
  output logic                 perra,
  output logic                 perrb
);

  localparam wr_mode_e WM = (WRITE_MODE == "WRITE_FIRST") ? WM_WRITE_FIRST :
                            (WRITE_MODE == "NO_CHANGE")   ? WM_NO_CHANGE   : WM_READ_FIRST;
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(RAM_DEPTH);
`ifdef BRAM_DUAL_PARITY_EN
  localparam int PW = NB;
`else
  localparam int PW = 0;
`endif
  localparam int SW = RAM_WIDTH + PW;

  if (RAM_WIDTH % 8 != 0) begin : g_bad_width
    $error("bram_dual_be: RAM_WIDTH must be a multiple of 8");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
    $error("bram_dual_be: READ_LATENCY must be 1 or 2");
  end

  logic [SW-1:0] mem_q [RAM_DEPTH];

  logic                 in_a, in_b, wr_a, wr_b, same_addr, coll_d;
  logic [SW-1:0]        rd_a, rd_b;
  logic [RAM_WIDTH-1:0] data_a, data_b;
  logic                 vld_a, vld_b, perr_a, perr_b;

  // Byte-wise merge; hi-priority enables override lo-priority ones, untouched bytes keep old_w.
  function automatic logic [RAM_WIDTH-1:0] merge(input logic [RAM_WIDTH-1:0] old_w,
                                                 input logic [NB-1:0]        we_hi,
                                                 input logic [RAM_WIDTH-1:0] din_hi,
                                                 input logic [NB-1:0]        we_lo,
                                                 input logic [RAM_WIDTH-1:0] din_lo);
    logic [RAM_WIDTH-1:0] w;
    w = old_w;
    for (int i = 0; i < NB; i++) begin
      if (we_hi[i])      w[8*i +: 8] = din_hi[8*i +: 8];
      else if (we_lo[i]) w[8*i +: 8] = din_lo[8*i +: 8];
    end
    return w;
  endfunction

`ifdef BRAM_DUAL_PARITY_EN
  function automatic logic parity_err(input logic [SW-1:0] w);
    logic e;
    e = 1'b0;
    for (int i = 0; i < NB; i++) e = e | (byte_parity(w[8*i +: 8]) ^ w[RAM_WIDTH+i]);
    return e;
  endfunction
`endif

  always_comb begin
    in_a      = ({1'b0, addra} < DEPTH_W);
    in_b      = ({1'b0, addrb} < DEPTH_W);
    wr_a      = ena && (|wea);
    wr_b      = enb && (|web);
    same_addr = ena && enb && (addra == addrb);
    coll_d    = same_addr && (wr_a || wr_b);
    rd_a      = in_a ? mem_q[addra] : '0;
    rd_b      = in_b ? mem_q[addrb] : '0;
    vld_a     = ena && !(wr_a && WM == WM_NO_CHANGE);
    vld_b     = enb && !(wr_b && WM == WM_NO_CHANGE);
    // A reader always sees the old word; only a WRITE_FIRST writer sees the final merged word.
    data_a    = rd_a[RAM_WIDTH-1:0];
    data_b    = rd_b[RAM_WIDTH-1:0];
    if (wr_a && in_a && WM == WM_WRITE_FIRST)
      data_a = merge(rd_a[RAM_WIDTH-1:0], wea, dina, (same_addr && wr_b) ? web : '0, dinb);
    if (wr_b && in_b && WM == WM_WRITE_FIRST)
      data_b = merge(rd_b[RAM_WIDTH-1:0], (same_addr && wr_a) ? wea : '0, dina, web, dinb);
    perr_a = 1'b0;
    perr_b = 1'b0;
`ifdef BRAM_DUAL_PARITY_EN
    perr_a = in_a && !(wr_a && WM == WM_WRITE_FIRST) && parity_err(rd_a);
    perr_b = in_b && !(wr_b && WM == WM_WRITE_FIRST) && parity_err(rd_b);
`endif
  end

  // Port B is written first so port A's bytes win on a same-address double write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_b && in_b && web[i]) begin
        mem_q[addrb][8*i +: 8] <= dinb[8*i +: 8];
`ifdef BRAM_DUAL_PARITY_EN
        mem_q[addrb][RAM_WIDTH+i] <= byte_parity(dinb[8*i +: 8]);
`endif
      end
    end
    for (int i = 0; i < NB; i++) begin
      if (wr_a && in_a && wea[i]) begin
        mem_q[addra][8*i +: 8] <= dina[8*i +: 8];
`ifdef BRAM_DUAL_PARITY_EN
        mem_q[addra][RAM_WIDTH+i] <= byte_parity(dina[8*i +: 8]);
`endif
      end
    end
  end

  logic coll_qa, coll_qb;

  bram_out_pipe #(.WIDTH(RAM_WIDTH), .LATENCY(READ_LATENCY)) u_pipe_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .vld_in   (vld_a),
    .data_in  (data_a),
    .perr_in  (perr_a),
    .coll_in  (coll_d),
    .data_out (douta),
    .vld_out  (dvalida),
    .perr_out (perra),
    .coll_out (coll_qa)
  );

  bram_out_pipe #(.WIDTH(RAM_WIDTH), .LATENCY(READ_LATENCY)) u_pipe_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .vld_in   (vld_b),
    .data_in  (data_b),
    .perr_in  (perr_b),
    .coll_in  (1'b0),
    .data_out (doutb),
    .vld_out  (dvalidb),
    .perr_out (perrb),
    .coll_out (coll_qb)
  );

  assign coll = coll_qa | coll_qb;

endmodule

// File: tb/tb_bram_dual_be.sv
// Random + directed bench for bram_dual_be: three instances (READ_FIRST/L1, WRITE_FIRST/L2,
// NO_CHANGE/L1) share stimulus and are checked against one word-level memory model.
`timescale 1ns/1ps
module tb_bram_dual_be;
  localparam int W = 32, DEPTH = 500, AW = 9, NB = 4, NI = 3, HN = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          ena = 1'b0, enb = 1'b0;
  logic [NB-1:0] wea = '0, web = '0;
  logic [AW-1:0] addra = '0, addrb = '0;
  logic [W-1:0]  dina = '0, dinb = '0;
  logic [W-1:0]  douta [NI];
  logic [W-1:0]  doutb [NI];
  logic          dvalida [NI];
  logic          dvalidb [NI];
  logic          coll [NI];
  logic          perra [NI];
  logic          perrb [NI];

  bram_dual_be #(.RAM_WIDTH(W), .RAM_DEPTH(DEPTH), .READ_LATENCY(1), .WRITE_MODE("READ_FIRST")) u_rf (
    .clk(clk), .rst_n(rst_n), .ena(ena), .enb(enb), .wea(wea), .web(web), .addra(addra), .addrb(addrb),
    .dina(dina), .dinb(dinb), .douta(douta[0]), .doutb(doutb[0]), .dvalida(dvalida[0]),
    .dvalidb(dvalidb[0]), .coll(coll[0]), .perra(perra[0]), .perrb(perrb[0]));
  bram_dual_be #(.RAM_WIDTH(W), .RAM_DEPTH(DEPTH), .READ_LATENCY(2), .WRITE_MODE("WRITE_FIRST")) u_wf (
    .clk(clk), .rst_n(rst_n), .ena(ena), .enb(enb), .wea(wea), .web(web), .addra(addra), .addrb(addrb),
    .dina(dina), .dinb(dinb), .douta(douta[1]), .doutb(doutb[1]), .dvalida(dvalida[1]),
    .dvalidb(dvalidb[1]), .coll(coll[1]), .perra(perra[1]), .perrb(perrb[1]));
  bram_dual_be #(.RAM_WIDTH(W), .RAM_DEPTH(DEPTH), .READ_LATENCY(1), .WRITE_MODE("NO_CHANGE")) u_nc (
    .clk(clk), .rst_n(rst_n), .ena(ena), .enb(enb), .wea(wea), .web(web), .addra(addra), .addrb(addrb),
    .dina(dina), .dinb(dinb), .douta(douta[2]), .doutb(doutb[2]), .dvalida(dvalida[2]),
    .dvalidb(dvalidb[2]), .coll(coll[2]), .perra(perra[2]), .perrb(perrb[2]));

  // mode: 0 read-first, 1 write-first, 2 no-change
  int lat  [NI] = '{1, 2, 1};
  int mode [NI] = '{0, 1, 2};

  typedef struct packed {
    logic         def;
    logic         v;
    logic         c;
    logic [W-1:0] d;
  } exp_t;

  logic [W-1:0] mref [DEPTH];
  exp_t         expa [NI][HN];
  exp_t         expb [NI][HN];
  logic [W-1:0] lasta [NI];
  logic [W-1:0] lastb [NI];
  int           ncyc = 0;
  int           checks = 0;
  int           errors = 0;
  bit           chk_en = 1'b0;

  always @(posedge clk) ncyc <= ncyc + 1;

  function automatic logic [W-1:0] write_bytes(input logic [W-1:0] old, input logic [NB-1:0] we,
                                               input logic [W-1:0] din);
    logic [W-1:0] r;
    r = old;
    for (int i = 0; i < NB; i++) if (we[i]) r[8*i +: 8] = din[8*i +: 8];
    return r;
  endfunction

  function automatic exp_t port_exp(input int md, input logic en, input logic wr, input logic inr,
                                    input logic [W-1:0] oldw, input logic [W-1:0] finalw,
                                    input logic cl, input logic [W-1:0] last);
    exp_t e;
    e.def = 1'b1;
    e.c   = cl;
    e.v   = 1'b0;
    e.d   = last;
    if (en && !(wr && md == 2)) begin
      e.v = 1'b1;
      e.d = !inr ? '0 : (wr && md == 1) ? finalw : oldw;
    end
    return e;
  endfunction

  // One access cycle: drive the ports at the negedge and record what every instance must show.
  task automatic step(input logic ea, input logic [NB-1:0] wa, input logic [AW-1:0] aa,
                      input logic [W-1:0] da, input logic eb, input logic [NB-1:0] wb,
                      input logic [AW-1:0] ab, input logic [W-1:0] db);
    logic [W-1:0] olda, oldb, fina, finb;
    logic ina, inb, wra, wrb, c;
    int idx;
    exp_t e;
    @(negedge clk);
    ena = ea; wea = wa; addra = aa; dina = da;
    enb = eb; web = wb; addrb = ab; dinb = db;
    ina  = (int'(aa) < DEPTH);
    inb  = (int'(ab) < DEPTH);
    wra  = ea && (wa != '0);
    wrb  = eb && (wb != '0);
    c    = ea && eb && (aa == ab) && (wra || wrb);
    olda = ina ? mref[aa] : '0;
    oldb = inb ? mref[ab] : '0;
    // B lands first, A overwrites its own bytes: A wins on shared bytes.
    if (wrb && inb) mref[ab] = write_bytes(mref[ab], wb, db);
    if (wra && ina) mref[aa] = write_bytes(mref[aa], wa, da);
    fina = ina ? mref[aa] : '0;
    finb = inb ? mref[ab] : '0;
    for (int i = 0; i < NI; i++) begin
      idx = (ncyc + lat[i]) % HN;
      e = port_exp(mode[i], ea, wra, ina, olda, fina, c, lasta[i]);
      expa[i][idx] = e;
      lasta[i] = e.d;
      e = port_exp(mode[i], eb, wrb, inb, oldb, finb, c, lastb[i]);
      expb[i][idx] = e;
      lastb[i] = e.d;
    end
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic lit(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  function automatic logic [AW-1:0] pick_addr();
    int r;
    r = $urandom_range(0, 19);
    if (r < 16) return AW'(r);
    return AW'(496 + $urandom_range(0, 15));
  endfunction

  always @(negedge clk) begin
    exp_t ea_, eb_;
    if (rst_n && chk_en) begin
      for (int i = 0; i < NI; i++) begin
        ea_ = expa[i][ncyc % HN];
        eb_ = expb[i][ncyc % HN];
        if (ea_.def) begin
          checks++;
          if (douta[i] !== ea_.d || dvalida[i] !== ea_.v || coll[i] !== ea_.c || perra[i] !== 1'b0) begin
            errors++;
            $display("FAIL cyc%0d inst%0d portA: dout=%h v=%b coll=%b perr=%b, required dout=%h v=%b coll=%b perr=0",
                     ncyc, i, douta[i], dvalida[i], coll[i], perra[i], ea_.d, ea_.v, ea_.c);
          end
        end
        if (eb_.def) begin
          checks++;
          if (doutb[i] !== eb_.d || dvalidb[i] !== eb_.v || perrb[i] !== 1'b0) begin
            errors++;
            $display("FAIL cyc%0d inst%0d portB: dout=%h v=%b perr=%b, required dout=%h v=%b perr=0",
                     ncyc, i, doutb[i], dvalidb[i], perrb[i], eb_.d, eb_.v);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] ra, rb;
    for (int i = 0; i < NI; i++) begin
      lasta[i] = '0;
      lastb[i] = '0;
      for (int k = 0; k < HN; k++) begin
        expa[i][k] = '0;
        expb[i][k] = '0;
      end
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      lit($sformatf("reset douta inst%0d", i), douta[i], '0);
      lit($sformatf("reset doutb inst%0d", i), doutb[i], '0);
      lit($sformatf("reset flags inst%0d", i),
          32'({dvalida[i], dvalidb[i], coll[i], perra[i], perrb[i]}), '0);
    end
    rst_n  = 1'b1;
    chk_en = 1'b1;

    for (int a = 0; a < 16; a++) step(1'b1, 4'hF, AW'(a), 32'h01010101 * a, 1'b0, '0, '0, '0);
    for (int a = 496; a < 500; a++) step(1'b0, '0, '0, '0, 1'b1, 4'hF, AW'(a), 32'h5A5A0000 + a);

    // byte write enables
    step(1'b1, 4'hF, 9'd5, 32'h11223344, 1'b0, '0, '0, '0);
    step(1'b1, 4'b0101, 9'd5, 32'hAABBCCDD, 1'b0, '0, '0, '0);
    step(1'b1, '0, 9'd5, '0, 1'b0, '0, '0, '0);
    idle();
    lit("byte_we rf", douta[0], 32'h11BB33DD);
    lit("byte_we nc", douta[2], 32'h11BB33DD);
    idle();
    lit("byte_we wf", douta[1], 32'h11BB33DD);

    // write modes
    step(1'b1, 4'hF, 9'd7, 32'h0, 1'b0, '0, '0, '0);
    step(1'b1, '0, 9'd5, '0, 1'b0, '0, '0, '0);
    idle();
    idle();
    step(1'b1, 4'hF, 9'd7, 32'hDEADBEEF, 1'b0, '0, '0, '0);
    idle();
    lit("wmode rf dout", douta[0], 32'h0);
    lit("wmode rf valid", 32'(dvalida[0]), 32'd1);
    lit("wmode nc dout held", douta[2], 32'h11BB33DD);
    lit("wmode nc valid", 32'(dvalida[2]), 32'd0);
    idle();
    lit("wmode wf dout", douta[1], 32'hDEADBEEF);
    lit("wmode wf valid", 32'(dvalida[1]), 32'd1);

    // write/write collision
    step(1'b1, 4'b0011, 9'd10, 32'h11111111, 1'b1, 4'hF, 9'd10, 32'h22222222);
    idle();
    lit("ww coll rf", 32'(coll[0]), 32'd1);
    lit("ww coll nc", 32'(coll[2]), 32'd1);
    idle();
    lit("ww coll wf", 32'(coll[1]), 32'd1);
    step(1'b1, '0, 9'd10, '0, 1'b1, '0, 9'd10, '0);
    idle();
    lit("ww word a", douta[0], 32'h22221111);
    lit("ww word b", doutb[0], 32'h22221111);
    lit("rr no coll", 32'(coll[0]), 32'd0);

    // write/read collision
    step(1'b1, 4'hF, 9'd9, 32'h3, 1'b0, '0, '0, '0);
    step(1'b1, 4'hF, 9'd9, 32'h5, 1'b1, '0, 9'd9, '0);
    idle();
    lit("wr rf doutb", doutb[0], 32'h3);
    lit("wr rf coll", 32'(coll[0]), 32'd1);
    lit("wr nc doutb", doutb[2], 32'h3);
    idle();
    lit("wr wf doutb", doutb[1], 32'h3);
    lit("wr wf douta", douta[1], 32'h5);

    // out of range
    step(1'b1, '0, 9'd505, '0, 1'b1, 4'hF, 9'd505, 32'hFFFFFFFF);
    idle();
    lit("oor rd data", douta[0], 32'h0);
    lit("oor rd valid", 32'(dvalida[0]), 32'd1);

    // asynchronous reset in the middle of a read
    step(1'b1, '0, 9'd5, '0, 1'b1, '0, 9'd9, '0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      lit($sformatf("midreset douta inst%0d", i), douta[i], '0);
      lit($sformatf("midreset flags inst%0d", i),
          32'({dvalida[i], dvalidb[i], coll[i], perra[i], perrb[i]}), '0);
      lasta[i] = '0;
      lastb[i] = '0;
      for (int k = 0; k < HN; k++) begin
        expa[i][k].def = 1'b0;
        expb[i][k].def = 1'b0;
      end
    end
    ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      idle();
      for (int i = 0; i < NI; i++)
        lit($sformatf("post reset valid inst%0d", i), 32'({dvalida[i], dvalidb[i]}), '0);
    end

    // randomized traffic
    repeat (2000) begin
      ra = pick_addr();
      rb = ($urandom_range(0, 3) == 0) ? ra : pick_addr();
      step($urandom_range(0, 3) != 0, ($urandom_range(0, 1) == 1) ? NB'($urandom) : '0, ra, $urandom,
           $urandom_range(0, 3) != 0, ($urandom_range(0, 1) == 1) ? NB'($urandom) : '0, rb, $urandom);
    end
    idle();
    idle();

`ifdef BRAM_DUAL_PARITY_EN
    chk_en = 1'b0;
    u_rf.mem_q[2][12] = ~u_rf.mem_q[2][12];
    step(1'b1, '0, 9'd2, '0, 1'b0, '0, '0, '0);
    idle();
    lit("parity err flag", 32'({perra[0], dvalida[0]}), 32'd3);
    step(1'b1, '0, 9'd3, '0, 1'b0, '0, '0, '0);
    idle();
    lit("parity clean flag", 32'({perra[0], dvalida[0]}), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
